// File: rtl/counters_pkg.sv
// Shared types and constants for the push-button front end and the counter blocks.
package counters_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } debounce_state_t;

    localparam int DEFAULT_PULSE_METER = 2000000;
    localparam int BOARD_CLK_HZ        = 50000000;

    // Bits needed to hold any value in 0..max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad input; reset value is a parameter so
// active-low pads can park in their idle level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one active-low push-button into a clean level plus press/release strobes.
// Optional hold-to-repeat on press_pulse is built when BUTTON_DEBOUNCER_AUTO_REPEAT_EN is defined.
module button_debouncer
    import counters_pkg::*;
#(
    parameter int PULSE_METER   = DEFAULT_PULSE_METER,
    parameter int CNT_WIDTH     = 25,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    if (PULSE_METER < 2 || longint'(PULSE_METER) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_meter
        $error("button_debouncer: PULSE_METER out of range for CNT_WIDTH");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_debouncer: repeat timing must be at least one cycle");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PULSE_METER - 1);

    logic            synced;
    logic            s;
    debounce_state_t state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic            press_next;
    logic            release_next;
    logic            level_next;
    logic            strobe_press;

    // Pad idles high (released), so the synchroniser parks at 1.
    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button),
        .q     (synced)
    );

    assign s = ~synced;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_next = PRESS_PEND;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next   = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_PEND;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            RELEASE_PEND: begin
                if (s) begin
                    state_next   = PRESSED;
                    cnt_next     = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = RELEASED;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next     = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == PRESSED) || (state_next == RELEASE_PEND);
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = count_width(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt, rep_cnt_next;
    logic             rep_phase, rep_phase_next;
    logic [REP_W-1:0] rep_target;
    logic             repeat_fire;

    // Counts only stable PRESSED cycles; RELEASE_PEND leaves it frozen so a bounce resumes it.
    always_comb begin
        rep_cnt_next   = rep_cnt;
        rep_phase_next = rep_phase;
        repeat_fire    = 1'b0;
        rep_target     = rep_phase ? REP_PERIOD_V : REP_DELAY_V;
        if (state == PRESSED && s) begin
            if (rep_cnt + 1'b1 == rep_target) begin
                repeat_fire    = 1'b1;
                rep_cnt_next   = '0;
                rep_phase_next = 1'b1;
            end else begin
                rep_cnt_next   = rep_cnt + 1'b1;
            end
        end else if (state == RELEASED || state == PRESS_PEND) begin
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_next;
            rep_phase <= rep_phase_next;
        end
    end

    assign strobe_press = press_next | repeat_fire;
`else
    assign strobe_press = press_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            btn_level     <= level_next;
            press_pulse   <= strobe_press;
            release_pulse <= release_next;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed latency/bounce/reset steps plus random
// bouncing, checked against a run-length reference model (repeat rule included when
// BUTTON_DEBOUNCER_AUTO_REPEAT_EN is defined).
module tb_button_debouncer;
    import counters_pkg::*;

    localparam int P  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk;
    logic reset;
    logic button;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model: pad pipeline, accepted level, run length of disagreeing samples.
    logic m_h1, m_h2;
    logic m_level;
    int   m_run;
    int   m_held;
    logic exp_press, exp_release;

    button_debouncer #(
        .PULSE_METER   (P),
        .CNT_WIDTH     (4),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button        (button),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A new level is accepted once the synchronised sample has disagreed for P edges in a row.
    task automatic model_edge(input logic b, input logic r);
        logic s;
        exp_press   = 1'b0;
        exp_release = 1'b0;
        if (r) begin
            m_h1 = 1'b1; m_h2 = 1'b1;
            m_level = 1'b0; m_run = 0; m_held = 0;
            return;
        end
        s    = ~m_h2;
        m_h2 = m_h1;
        m_h1 = b;
        if (s != m_level) begin
            m_run++;
            if (m_run == P) begin
                m_level = s;
                m_run   = 0;
                m_held  = 0;
                if (s) exp_press = 1'b1;
                else   exp_release = 1'b1;
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (m_level) begin
            m_held++;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
            if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0))
                exp_press = 1'b1;
`endif
        end
    endtask

    task automatic tick(input logic b, input logic r);
        button = b;
        reset  = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check("press_pulse", {31'd0, press_pulse}, {31'd0, exp_press});
        check("release_pulse", {31'd0, release_pulse}, {31'd0, exp_release});
        check("btn_level", {31'd0, btn_level}, {31'd0, m_level});
        check("no_double_strobe", {31'd0, press_pulse & release_pulse}, 32'd0);
        if (r) check("reset_state", {30'd0, dut.state}, {30'd0, RELEASED});
    endtask

    // Hold the button at b and return the tick index (1-based) where the strobe appears.
    task automatic wait_strobe(input logic b, input logic want_press, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(b, 1'b0);
            if ((want_press ? press_pulse : release_pulse) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int presses;
        int exp_repeats;
        button = 1'b1;
        reset  = 1'b1;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);

        // Clean press: strobe P+2 ticks after the first sampling edge.
        wait_strobe(1'b0, 1'b1, lat);
        check("press_latency", lat, P + 2);
        check("level_after_press", {31'd0, btn_level}, 32'd1);

        // Hold: count additional press strobes over 30 cycles.
        presses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            if (press_pulse === 1'b1) presses++;
        end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        exp_repeats = 7;
`else
        exp_repeats = 0;
`endif
        check("held_repeats", presses, exp_repeats);

        // Clean release.
        wait_strobe(1'b1, 1'b0, lat);
        check("release_latency", lat, P + 2);
        check("level_after_release", {31'd0, btn_level}, 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

        // Bounce 0,1,0,1 then settle low: one strobe P+2 after the settle edge.
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        wait_strobe(1'b0, 1'b1, lat);
        check("bounce_press_latency", lat, P + 2);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        wait_strobe(1'b1, 1'b0, lat);
        check("release_latency_2", lat, P + 2);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

        // Reset while PRESS_PEND has cnt=P-1, then re-accept the still-held button.
        for (int i = 0; i < P + 1; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("press_after_reset_hit", {31'd0, press_pulse}, 32'd0);
        wait_strobe(1'b0, 1'b1, lat);
        check("press_after_reset_latency", lat, P + 2);

        // Random bouncing with occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * P + 2);
            for (int k = 0; k < len; k++) tick(b, ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
